// File: rtl/vec_arith_array.sv
// Vector arithmetic array: NUM_PE 32-bit PE lanes with elementwise and ripple-reduction modes.
// Optional feature macro: AVA_ARITH_OUT_REG_EN (registered output stage); default is combinational output.
package pe_pkg;
  typedef enum logic [2:0] {PE_ADD, PE_SUB, PE_MUL, PE_MACC, PE_MIN, PE_MAX, PE_AND, PE_XOR} pe_arith_op_t;
  typedef enum logic [1:0] {SAT_NONE, SAT_SIGNED, SAT_UNSIGNED, SAT_RSVD} pe_saturate_mode_t;
  typedef enum logic [0:0] {OUT_LOW, OUT_HIGH} pe_output_mode_t;
  typedef enum logic [1:0] {OPSEL_VS1, OPSEL_SCALAR, OPSEL_IMM, OPSEL_RIPPLE} pe_operand_t;
endpackage

module pe_32b
  import pe_pkg::*;
(
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  input  logic [31:0]       c_i,
  input  pe_arith_op_t      op_i,
  input  pe_saturate_mode_t sat_i,
  input  pe_output_mode_t   omode_i,
  input  logic [1:0]        widening_i,
  input  logic [1:0]        mul_us_i,
  input  logic [1:0]        vsew_i,
  output logic [31:0]       y_o
);
  // Clamp bytes st..hi of one element when its add/sub overflowed.
  function automatic logic [31:0] sat_elem(input logic [31:0] r, input logic sa, input logic sb,
                                           input logic co, input logic sub, input int st,
                                           input int hi, input pe_saturate_mode_t sat);
    logic [31:0] y;
    logic        ovf_s, ovf_u;
    y     = r;
    ovf_s = (sa == sb) && (r[8*hi+7] != sa);
    ovf_u = sub ? ~co : co;
    for (int j = 0; j < 4; j++) begin
      if (j >= st && j <= hi) begin
        if (sat == SAT_SIGNED && ovf_s)
          y[8*j+:8] = (j == hi) ? {sa, {7{~sa}}} : {8{~sa}};
        else if (sat == SAT_UNSIGNED && ovf_u)
          y[8*j+:8] = {8{~sub}};
      end
    end
    return y;
  endfunction

  // SIMD add/sub: carries are broken at element boundaries set by vsew (0=8b, 1=16b, else 32b).
  function automatic logic [31:0] simd_addsub(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub, input logic [1:0] sew,
                                              input pe_saturate_mode_t sat);
    logic [31:0] r;
    logic [7:0]  bb;
    logic [8:0]  s;
    logic        cy;
    int          st;
    r  = '0;
    cy = 1'b0;
    st = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || sew == 2'd0 || (sew == 2'd1 && k == 2)) begin
        cy = sub;
        st = k;
      end
      bb        = sub ? ~b[8*k+:8] : b[8*k+:8];
      s         = {1'b0, a[8*k+:8]} + {1'b0, bb} + {8'd0, cy};
      r[8*k+:8] = s[7:0];
      cy        = s[8];
      if (k == 3 || sew == 2'd0 || (sew == 2'd1 && k == 1))
        r = sat_elem(r, a[8*k+7], bb[7], cy, sub, st, k, sat);
    end
    return r;
  endfunction

  logic [31:0]        ma_src, mb_src, mul_res;
  logic signed [32:0] ma, mb;
  logic signed [63:0] prod;
  logic               lt;

  always_comb begin
    ma_src  = widening_i[0] ? {{16{~mul_us_i[0] & a_i[15]}}, a_i[15:0]} : a_i;
    mb_src  = widening_i[1] ? {{16{~mul_us_i[1] & b_i[15]}}, b_i[15:0]} : b_i;
    ma      = {~mul_us_i[0] & ma_src[31], ma_src};
    mb      = {~mul_us_i[1] & mb_src[31], mb_src};
    prod    = ma * mb;
    mul_res = (omode_i == OUT_HIGH) ? prod[63:32] : prod[31:0];
    lt      = mul_us_i[0] ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
    case (op_i)
      PE_ADD:  y_o = simd_addsub(a_i, b_i, 1'b0, vsew_i, sat_i);
      PE_SUB:  y_o = simd_addsub(a_i, b_i, 1'b1, vsew_i, sat_i);
      PE_MUL:  y_o = mul_res;
      PE_MACC: y_o = mul_res + c_i;
      PE_MIN:  y_o = lt ? a_i : b_i;
      PE_MAX:  y_o = lt ? b_i : a_i;
      PE_AND:  y_o = a_i & b_i;
      PE_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end
endmodule

module scalar_replicate #(
  parameter int NUM_PE = 4
) (
  input  logic [31:0]          scalar_i,
  output logic [32*NUM_PE-1:0] rep_o
);
  assign rep_o = {NUM_PE{scalar_i}};
endmodule

module vec_arith_array
  import pe_pkg::*;
#(
  parameter int NUM_PE = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [32*NUM_PE-1:0]          vs1_data,
  input  logic [32*NUM_PE-1:0]          vs2_data,
  input  logic [32*NUM_PE-1:0]          vs3_data,
  input  logic [31:0]                   scalar_operand,
  input  logic [4:0]                    imm_operand,
  input  pe_arith_op_t                  op,
  input  pe_saturate_mode_t             saturate_mode,
  input  pe_output_mode_t               output_mode,
  input  pe_operand_t                   operand_select,
  input  logic [1:0]                    widening,
  input  logic [1:0]                    mul_us,
  input  logic [1:0]                    vsew,
  input  logic [$clog2(NUM_PE)-1:0]     vl_tail,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [32*NUM_PE-1:0]          arith_output,
  output logic [32*NUM_PE-1:0]          replicated_scalar,
  output logic                          busy
);
  localparam int DATA_W = 32 * NUM_PE;
  localparam int TW     = $clog2(NUM_PE);

  typedef enum logic {S_IDLE, S_REDUCE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         imm_ext;
  logic [DATA_W-1:0]   result, out_data;
  logic [TW-1:0]       tail_idx;
  logic                is_ripple, produces, accept;

  assign imm_ext = {27'd0, imm_operand};

  scalar_replicate #(.NUM_PE(NUM_PE)) u_rep (
    .scalar_i (operand_select == OPSEL_IMM ? imm_ext : scalar_operand),
    .rep_o    (replicated_scalar)
  );

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
    logic [31:0] b, y, ripple_in;
    if (gi == 0) begin : g_seed
      assign ripple_in = in_first ? vs1_data[31:0] : acc_q;
    end else begin : g_chain
      assign ripple_in = g_lane[gi-1].y;
    end
    always_comb begin
      case (operand_select)
        OPSEL_VS1:    b = vs1_data[32*gi+:32];
        OPSEL_SCALAR: b = replicated_scalar[32*gi+:32];
        OPSEL_IMM:    b = imm_ext;
        default:      b = ripple_in;
      endcase
    end
    pe_32b u_pe (
      .a_i        (vs2_data[32*gi+:32]),
      .b_i        (b),
      .c_i        (vs3_data[32*gi+:32]),
      .op_i       (op),
      .sat_i      (saturate_mode),
      .omode_i    (output_mode),
      .widening_i (widening),
      .mul_us_i   (mul_us),
      .vsew_i     (vsew),
      .y_o        (y)
    );
    assign result[32*gi+:32] = y;
  end

  // vl_tail=0 wraps to NUM_PE-1, selecting the last lane.
  assign tail_idx  = vl_tail - TW'(1);
  assign is_ripple = (operand_select == OPSEL_RIPPLE);
  assign produces  = ~is_ripple | in_last;
  assign accept    = in_valid & in_ready;
  assign out_data  = is_ripple ? {{(DATA_W-32){1'b0}}, result[{tail_idx, 5'd0} +: 32]} : result;
  assign busy      = (state_q == S_REDUCE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (accept && is_ripple) begin
      if (in_last) begin
        state_d = S_IDLE;
      end else begin
        acc_d = result[DATA_W-1 -: 32];
        if (in_first) state_d = S_REDUCE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

`ifdef AVA_ARITH_OUT_REG_EN
  logic              out_valid_q;
  logic [DATA_W-1:0] arith_q;

  assign in_ready     = produces ? (~out_valid_q | out_ready) : 1'b1;
  assign out_valid    = out_valid_q;
  assign arith_output = arith_q;

  // Output stage: one-deep skid-free register, refilled on the same edge it drains.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_valid_q <= 1'b0;
      arith_q     <= '0;
    end else if (accept && produces) begin
      out_valid_q <= 1'b1;
      arith_q     <= out_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready     = produces ? out_ready : 1'b1;
  assign out_valid    = in_valid & produces;
  assign arith_output = out_data;
`endif
endmodule

// File: tb/tb_vec_arith_array.sv
// Scoreboard bench for vec_arith_array (default combinational-output build, NUM_PE=4).
module tb_vec_arith_array;
  import pe_pkg::*;

  localparam int NUM_PE = 4;
  localparam int DW     = 32 * NUM_PE;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              in_valid, in_ready, in_first, in_last;
  logic [DW-1:0]     vs1_data, vs2_data, vs3_data;
  logic [31:0]       scalar_operand;
  logic [4:0]        imm_operand;
  pe_arith_op_t      op;
  pe_saturate_mode_t saturate_mode;
  pe_output_mode_t   output_mode;
  pe_operand_t       operand_select;
  logic [1:0]        widening, mul_us, vsew;
  logic [1:0]        vl_tail;
  logic              out_valid, out_ready, busy;
  logic [DW-1:0]     arith_output, replicated_scalar;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  vec_arith_array #(.NUM_PE(NUM_PE)) dut (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .vs1_data(vs1_data), .vs2_data(vs2_data),
    .vs3_data(vs3_data), .scalar_operand(scalar_operand), .imm_operand(imm_operand),
    .op(op), .saturate_mode(saturate_mode), .output_mode(output_mode),
    .operand_select(operand_select), .widening(widening), .mul_us(mul_us), .vsew(vsew),
    .vl_tail(vl_tail), .out_valid(out_valid), .out_ready(out_ready),
    .arith_output(arith_output), .replicated_scalar(replicated_scalar), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] L(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no output", arith_output);
      end else begin
        check("output", arith_output, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DW-1:0] v1, input logic [DW-1:0] v2, input pe_operand_t sel,
                      input logic first, input logic last, input logic [1:0] tail,
                      input logic expect_out, input logic [DW-1:0] exp);
    bit ok = 1'b0;
    vs1_data = v1; vs2_data = v2; operand_select = sel;
    in_first = first; in_last = last; vl_tail = tail;
    if (expect_out) exp_q.push_back(exp);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    vs1_data = '0; vs2_data = '0; vs3_data = '0; scalar_operand = '0; imm_operand = '0;
    op = PE_ADD; saturate_mode = SAT_NONE; output_mode = OUT_LOW; operand_select = OPSEL_VS1;
    widening = 2'd0; mul_us = 2'd0; vsew = 2'd2; vl_tail = 2'd0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", DW'(busy), DW'(0));
    check("reset_out_valid", DW'(out_valid), DW'(0));
    check("reset_acc", DW'(dut.acc_q), DW'(0));
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Elementwise VS1 add
    send(L(10, 20, 30, 40), L(1, 2, 3, 4), OPSEL_VS1, 0, 0, 0, 1, L(11, 22, 33, 44));

    // Scalar add plus replication
    scalar_operand = 32'd5;
    operand_select = OPSEL_SCALAR;
    #1 check("replicated_scalar", replicated_scalar, L(5, 5, 5, 5));
    send('0, L(7, 7, 7, 7), OPSEL_SCALAR, 0, 0, 0, 1, L(12, 12, 12, 12));

    // Immediate operand, zero-extended and replicated
    imm_operand = 5'd9;
    operand_select = OPSEL_IMM;
    #1 check("replicated_imm", replicated_scalar, L(9, 9, 9, 9));
    send('0, L(1, 2, 3, 4), OPSEL_IMM, 0, 0, 0, 1, L(10, 11, 12, 13));

    // Subtract, saturation and element width
    op = PE_SUB;
    send(L(1, 2, 3, 4), L(10, 20, 30, 40), OPSEL_VS1, 0, 0, 0, 1, L(9, 18, 27, 36));
    op = PE_ADD; saturate_mode = SAT_UNSIGNED;
    send(L(2, 0, 0, 0), L(32'hFFFF_FFFF, 0, 0, 0), OPSEL_VS1, 0, 0, 0, 1,
         L(32'hFFFF_FFFF, 0, 0, 0));
    saturate_mode = SAT_SIGNED;
    send(L(1, 32'hFFFF_FFFF, 6, 0), L(32'h7FFF_FFFF, 32'h8000_0000, 5, 0), OPSEL_VS1, 0, 0, 0, 1,
         L(32'h7FFF_FFFF, 32'h8000_0000, 11, 0));
    saturate_mode = SAT_NONE; vsew = 2'd0;
    send(L(32'h0001_0001, 1, 0, 0), L(32'h00FF_00FF, 32'h7F, 0, 0), OPSEL_VS1, 0, 0, 0, 1,
         L(0, 32'h80, 0, 0));
    vsew = 2'd2;

    // Unsigned multiply, high half
    op = PE_MUL; output_mode = OUT_HIGH; mul_us = 2'b11;
    send(L(4, 32'h1_0000, 32'hFFFF_FFFF, 0), L(3, 32'h1_0000, 2, 0), OPSEL_VS1, 0, 0, 0, 1,
         L(0, 1, 1, 0));
    op = PE_ADD; output_mode = OUT_LOW; mul_us = 2'b00;

    // Two-beat reduction
    send(L(100, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 0, 0, 0, '0);
    check("red_busy_beat1", DW'(busy), DW'(1));
    check("red_acc_beat1", DW'(dut.acc_q), DW'(110));
    send('0, L(5, 6, 7, 8), OPSEL_RIPPLE, 0, 1, 0, 1, L(136, 0, 0, 0));
    check("red_busy_done", DW'(busy), DW'(0));

    // Single-beat reductions with tails
    send(L(0, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 1, 2, 1, L(3, 0, 0, 0));
    check("single_busy", DW'(busy), DW'(0));
    send(L(50, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 1, 1, 1, L(51, 0, 0, 0));
    send(L(50, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 1, 3, 1, L(56, 0, 0, 0));

    // Elementwise beat in the middle of a reduction leaves acc and state alone
    send(L(100, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 0, 0, 0, '0);
    send(L(1, 1, 1, 1), L(2, 2, 2, 2), OPSEL_VS1, 0, 0, 0, 1, L(3, 3, 3, 3));
    check("mid_acc", DW'(dut.acc_q), DW'(110));
    check("mid_busy", DW'(busy), DW'(1));
    send('0, L(5, 6, 7, 8), OPSEL_RIPPLE, 0, 1, 0, 1, L(136, 0, 0, 0));

    // Backpressure with a pending output
    out_ready = 1'b0;
    vs1_data = L(1, 2, 3, 4); vs2_data = L(7, 7, 7, 7); operand_select = OPSEL_VS1;
    exp_q.push_back(L(8, 9, 10, 11));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", DW'(out_valid), DW'(1));
      check("bp_in_ready", DW'(in_ready), DW'(0));
      check("bp_stable", arith_output, L(8, 9, 10, 11));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Reset mid-reduction; first beat issued while downstream stalls
    out_ready = 1'b0;
    send(L(100, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 0, 0, 0, '0);
    check("pre_reset_busy", DW'(busy), DW'(1));
    out_ready = 1'b1;
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_reset_busy", DW'(busy), DW'(0));
    check("mid_reset_acc", DW'(dut.acc_q), DW'(0));
    check("mid_reset_out_valid", DW'(out_valid), DW'(0));
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    send(L(0, 0, 0, 0), L(1, 2, 3, 4), OPSEL_RIPPLE, 1, 1, 0, 1, L(10, 0, 0, 0));
    check("post_reset_busy", DW'(busy), DW'(0));

    repeat (2) @(posedge clk);
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_arith_array.md
VEC_ARITH_ARRAY -- requirements
Module: vec_arith_array

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of 32-bit PE lanes; legal values are 2, 4 and 8.
REQ-002 SHALL derive DATA_W = 32*NUM_PE and TW = log2(NUM_PE); these are localparams, not overridable.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; n_reset in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; in_first in 1, first beat of a reduction; in_last in 1, last beat of a reduction.
REQ-005 SHALL have ports: vs1_data, vs2_data, vs3_data in DATA_W; scalar_operand in 32; imm_operand in 5.
REQ-006 SHALL have ports: op in pe_arith_op_t; saturate_mode in pe_saturate_mode_t; output_mode in pe_output_mode_t; operand_select in pe_operand_t; widening in 2; mul_us in 2; vsew in 2.
REQ-007 SHALL have port vl_tail in TW: active lanes in the last reduction beat; 0 means all NUM_PE lanes are active.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; arith_output out DATA_W; replicated_scalar out DATA_W, combinational; busy out 1, high in state REDUCE.

Function
REQ-009 SHALL instantiate NUM_PE pe_32b lanes; lane i takes a=vs2[32i+:32], c=vs3[32i+:32] and the shared control inputs.
REQ-010 SHALL select lane b operand by operand_select:
- VS1: vs1 slice.
- SCALAR: replicated_scalar slice.
- IMMEDIATE: zero-extended imm_operand.
- RIPPLE: lane0 = vs1[31:0] on an in_first beat, else acc_reg; lane i>0 = output of lane i-1.
REQ-011 SHALL drive replicated_scalar from scalar_replicate; its input is zero-extended imm_operand when operand_select=IMMEDIATE, else scalar_operand.
REQ-012 SHALL accept a beat when in_valid and in_ready are both high; all other cycles leave state unchanged.
REQ-013 SHALL give each accepted non-RIPPLE beat exactly one output beat, arith_output = {lane NUM_PE-1 .. lane0}.
REQ-014 SHALL run a two-state FSM:
- IDLE -> REDUCE on an accepted RIPPLE beat with in_first=1 and in_last=0.
- REDUCE -> IDLE on an accepted RIPPLE beat with in_last=1.
- An accepted in_first beat while in REDUCE restarts the reduction and reseeds lane0 from vs1.
REQ-015 SHALL load acc_reg (32 bits) from lane NUM_PE-1 on every accepted RIPPLE beat with in_last=0; acc_reg holds on all other cycles.
REQ-016 SHALL produce exactly one output on an accepted RIPPLE beat with in_last=1; it is the zero-extended output of lane (vl_tail-1), or lane NUM_PE-1 when vl_tail=0.
REQ-017 SHALL treat in_first=in_last=1 as a complete single-beat reduction: no state change, one output.
REQ-018 SHALL produce no output for RIPPLE beats with in_last=0; in_ready is 1 for those beats regardless of out_ready.
REQ-019 SHALL accept and process non-RIPPLE beats in state REDUCE without modifying acc_reg or the FSM state.
REQ-020 SHALL hold arith_output stable while out_valid=1 and out_ready=0.

Reset
REQ-021 SHALL, while n_reset=0, force: state=IDLE, acc_reg=0, out_valid=0, busy=0, arith_output=0 (when registered).
REQ-022 SHALL, on reset asserted mid-reduction, discard all partial results; no output is produced for the discarded reduction.

Configuration
REQ-023 SHALL, with AVA_ARITH_OUT_REG_EN defined, register the output:
- Output beat appears the cycle after acceptance.
- in_ready = ~out_valid | out_ready for output-producing beats.
- Sustains one beat per cycle under continuous out_ready.
REQ-024 SHALL, without AVA_ARITH_OUT_REG_EN, make the output combinational:
- out_valid = in_valid & (non-RIPPLE | in_last).
- in_ready = out_ready for output-producing beats.
- Zero latency; no output register exists.

Verification
REQ-025 SHALL cover elementwise: NUM_PE=4, vsew=32b, op add, VS1, vs2 lanes {1,2,3,4}, vs1 lanes {10,20,30,40} -> arith_output lanes {11,22,33,44}, one beat.
REQ-026 SHALL cover scalar: op add, SCALAR, scalar_operand=5, vs2 all 7 -> all lanes 12; replicated_scalar = 4 copies of 5.
REQ-027 SHALL cover two-beat reduction: op add, RIPPLE, vl_tail=0.
- Beat1: first=1, vs1[0]=100, vs2 {1,2,3,4}; no output, busy=1, acc_reg=110.
- Beat2: last=1, vs2 {5,6,7,8}; output=136, busy=0.
REQ-028 SHALL cover single-beat tail: op add, RIPPLE, first=last=1, vl_tail=2, vs1[0]=0, vs2 {1,2,3,4} -> output=3 zero-extended; FSM stays IDLE.
REQ-029 SHALL cover backpressure: out_ready=0 for 3 cycles with a pending output -> arith_output stable, no further output-producing beat accepted; then out_ready=1 -> transfers next cycle.
REQ-030 SHALL cover reset: n_reset pulsed low after beat1 of REQ-027 -> busy=0, acc_reg=0, no output; a new single-beat reduction then yields a correct result.
